// File: rtl/report_collector_c2lw.sv
`default_nettype none
// ============================================================================
//  Module   : report_collector_c2lw
//  Purpose  : Timestamps cluster-2 load/store automata report cycles with the
//             symbol offset and buffers them in a FWFT FIFO for readout.
//  Revision : 1.0  initial release
// ============================================================================
module report_collector_c2lw #(
    parameter int NUM_REPORTS = 40,
    parameter int CNT_W       = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int DROP_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic [NUM_REPORTS-1:0]        reports,
    input  logic                          clr_status,
    output logic                          rpt_valid,
    input  logic                          rpt_ready,
    output logic [CNT_W-1:0]              rpt_offset,
    output logic [NUM_REPORTS-1:0]        rpt_vector,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [DROP_W-1:0]             drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [LVL_W-1:0]  c_DEPTH    = LVL_W'(FIFO_DEPTH);
    localparam logic [DROP_W-1:0] c_DROP_MAX = {DROP_W{1'b1}};

    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       r_mem_off [FIFO_DEPTH];
    logic [NUM_REPORTS-1:0] r_mem_vec [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [LVL_W-1:0]       r_level;
    logic                   r_overflow;
    logic [DROP_W-1:0]      r_drop_count;

    logic                   w_capture;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_push;
    logic                   w_drop;
    logic [CNT_W-1:0]       w_count_nxt;
    logic [PTR_W-1:0]       w_wr_ptr_nxt;
    logic [PTR_W-1:0]       w_rd_ptr_nxt;
    logic [LVL_W-1:0]       w_level_nxt;
    logic                   w_overflow_nxt;
    logic [DROP_W-1:0]      w_drop_count_nxt;

    assign w_capture = run && (reports != '0);
    assign w_pop     = rpt_valid && rpt_ready;
    assign w_full    = (r_level == c_DEPTH);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && w_full && !w_pop;

    always_comb begin
        w_count_nxt  = run    ? r_count  + CNT_W'(1) : r_count;
        w_wr_ptr_nxt = w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
        w_rd_ptr_nxt = w_pop  ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LVL_W'(1);
            2'b01:   w_level_nxt = r_level - LVL_W'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Clear is applied first so a coinciding drop leaves overflow=1, count=1.
    always_comb begin
        w_overflow_nxt   = r_overflow;
        w_drop_count_nxt = r_drop_count;
        if (clr_status) begin
            w_overflow_nxt   = 1'b0;
            w_drop_count_nxt = '0;
        end
        if (w_drop) begin
            w_overflow_nxt = 1'b1;
            if (w_drop_count_nxt != c_DROP_MAX) begin
                w_drop_count_nxt = w_drop_count_nxt + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_count      <= w_count_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_level      <= w_level_nxt;
            r_overflow   <= w_overflow_nxt;
            r_drop_count <= w_drop_count_nxt;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever empty.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem_off[r_wr_ptr] <= r_count;
            r_mem_vec[r_wr_ptr] <= reports;
        end
    end

    assign rpt_valid  = (r_level != '0);
    assign rpt_offset = rpt_valid ? r_mem_off[r_rd_ptr] : '0;
    assign rpt_vector = rpt_valid ? r_mem_vec[r_rd_ptr] : '0;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_report_collector_c2lw.sv
`default_nettype none
// ============================================================================
//  Module   : tb_report_collector_c2lw
//  Purpose  : Self-checking bench for report_collector_c2lw using a
//             queue-based reference model plus directed literal checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_report_collector_c2lw;

    localparam int NR = 40;
    localparam int CW = 32;
    localparam int FD = 8;
    localparam int DW = 16;

    typedef struct packed {
        logic [CW-1:0] off;
        logic [NR-1:0] vec;
    } rec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic [NR-1:0] reports;
    logic          clr_status;
    logic          rpt_ready;
    logic          rpt_valid;
    logic [CW-1:0] rpt_offset;
    logic [NR-1:0] rpt_vector;
    logic [3:0]    fifo_level;
    logic          overflow;
    logic [DW-1:0] drop_count;

    int n_checks = 0;
    int n_pass   = 0;

    rec_t          q[$];
    logic [CW-1:0] m_cnt  = '0;
    logic          m_ovf  = 1'b0;
    logic [DW-1:0] m_drop = '0;

    report_collector_c2lw #(
        .NUM_REPORTS(NR), .CNT_W(CW), .FIFO_DEPTH(FD), .DROP_W(DW)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .reports(reports),
        .clr_status(clr_status), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_offset(rpt_offset), .rpt_vector(rpt_vector),
        .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: plain queue semantics, then compare 1 time unit later.
    always @(posedge clk) begin
        rec_t r;
        logic popped;
        if (reset) begin
            q.delete();
            m_cnt  = '0;
            m_ovf  = 1'b0;
            m_drop = '0;
        end else begin
            popped = (q.size() != 0) && rpt_ready;
            if (clr_status) begin
                m_ovf  = 1'b0;
                m_drop = '0;
            end
            if (popped) void'(q.pop_front());
            if (run && reports != '0) begin
                if (q.size() < FD) begin
                    r.off = m_cnt;
                    r.vec = reports;
                    q.push_back(r);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end
            end
            if (run) m_cnt = m_cnt + 32'd1;
        end
        #1;
        check("model_valid",  64'(rpt_valid),  64'(q.size() != 0));
        check("model_offset", 64'(rpt_offset), (q.size() != 0) ? 64'(q[0].off) : 64'd0);
        check("model_vector", 64'(rpt_vector), (q.size() != 0) ? 64'(q[0].vec) : 64'd0);
        check("model_level",  64'(fifo_level), 64'(q.size()));
        check("model_ovf",    64'(overflow),   64'(m_ovf));
        check("model_drop",   64'(drop_count), 64'(m_drop));
    end

    task automatic step(input logic r, input logic [NR-1:0] rep, input logic rdy,
                        input logic clr, input logic rst);
        run        = r;
        reports    = rep;
        rpt_ready  = rdy;
        clr_status = clr;
        reset      = rst;
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        do_reset();
        check("rst_valid", 64'(rpt_valid), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_offset", 64'(rpt_offset), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);

        // Single record at offset 5, ready asserted at capture: no bypass
        for (int i = 0; i < 5; i++) step(1'b1, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 40'h1, 1'b1, 1'b0, 1'b0);
        check("t1_valid", 64'(rpt_valid), 64'd1);
        check("t1_offset", 64'(rpt_offset), 64'd5);
        check("t1_vector", 64'(rpt_vector), 64'h1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t1_empty", 64'(rpt_valid), 64'd0);

        // Fill past full: 8 buffered, 2 dropped
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 40'h8000000001, 1'b0, 1'b0, 1'b0);
        check("t2_level", 64'(fifo_level), 64'd8);
        check("t2_ovf", 64'(overflow), 64'd1);
        check("t2_drop", 64'(drop_count), 64'd2);
        check("t2_head", 64'(rpt_offset), 64'd0);

        // Full with simultaneous capture and pop
        step(1'b1, 40'h2, 1'b1, 1'b0, 1'b0);
        check("t3_level", 64'(fifo_level), 64'd8);
        check("t3_drop", 64'(drop_count), 64'd2);
        for (int i = 0; i < 8; i++) begin
            check("t3_drain_off", 64'(rpt_offset), (i < 7) ? 64'(i + 1) : 64'd10);
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        check("t3_drained", 64'(fifo_level), 64'd0);

        // run toggles 1,0,1
        do_reset();
        step(1'b1, 40'h3, 1'b0, 1'b0, 1'b0);
        step(1'b0, 40'h3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 40'h3, 1'b0, 1'b0, 1'b0);
        check("t4_level", 64'(fifo_level), 64'd2);
        check("t4_head0", 64'(rpt_offset), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t4_head1", 64'(rpt_offset), 64'd1);
        check("t4_vec1", 64'(rpt_vector), 64'h3);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // clr_status coinciding with a drop
        do_reset();
        for (int i = 0; i < 11; i++) step(1'b1, 40'h1, 1'b0, 1'b0, 1'b0);
        check("t5_drop3", 64'(drop_count), 64'd3);
        step(1'b1, 40'h1, 1'b0, 1'b1, 1'b0);
        check("t5_clrdrop_ovf", 64'(overflow), 64'd1);
        check("t5_clrdrop_cnt", 64'(drop_count), 64'd1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("t5_clr_ovf", 64'(overflow), 64'd0);
        check("t5_clr_cnt", 64'(drop_count), 64'd0);

        // Reset mid-operation with 4 records buffered
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 40'h7, 1'b0, 1'b0, 1'b0);
        check("t6_level4", 64'(fifo_level), 64'd4);
        step(1'b1, 40'h1, 1'b0, 1'b0, 1'b1);
        check("t6_rst_valid", 64'(rpt_valid), 64'd0);
        check("t6_rst_level", 64'(fifo_level), 64'd0);
        step(1'b1, 40'h5, 1'b0, 1'b0, 1'b0);
        check("t6_off0", 64'(rpt_offset), 64'd0);
        check("t6_vec", 64'(rpt_vector), 64'h5);

        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
